// File: rtl/bcd_digit_overlay.sv
// bcd_digit_overlay: draws a 3-digit packed-BCD value as scaled seven-segment
// glyphs on top of the pixel stream, with a per-frame shadow of the value and
// a fixed 2-cycle pixel pipeline.
module bcd_digit_overlay #(
    parameter int unsigned X0         = 16,
    parameter int unsigned Y0         = 16,
    parameter int unsigned SCALE_LOG2 = 2,
    parameter logic [23:0] FG         = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] valor_bcd,
    input  logic        frame_start,
    input  logic [10:0] pixel_x,
    input  logic [10:0] pixel_y,
    input  logic        de_in,
    input  logic [23:0] rgb_in,
    output logic        de_out,
    output logic [23:0] rgb_out
);

    localparam int unsigned BOX_W_UNITS = 15;
    localparam int unsigned BOX_H_UNITS = 7;
    localparam int unsigned X_END       = X0 + (BOX_W_UNITS << SCALE_LOG2);
    localparam int unsigned Y_END       = Y0 + (BOX_H_UNITS << SCALE_LOG2);

    // Shadow copy of the displayed value
    logic [11:0] shown_q;

    // Stage 1 registers
    logic        in_box_q, in_box_d;
    logic [2:0]  col_q,    col_d;
    logic [2:0]  uy_q,     uy_d;
    logic [3:0]  nib_q,    nib_d;
    logic        blank_q,  blank_d;
    logic        de1_q;
    logic [23:0] rgb1_q;

    // Stage 2 next-state
    logic [23:0] rgb_out_d;

    // Stage 1 intermediates
    logic        in_x_c, in_y_c;
    logic [10:0] dx_c, dy_c;
    logic [10:0] ux_full_c, uy_full_c;
    logic [3:0]  ux_c;
    logic [1:0]  digit_c;

    // Stage 2 intermediates
    logic [6:0]  seg_c;
    logic        lit_c;

    // Seven-segment pattern {a,b,c,d,e,f,g}; non-decimal nibbles show a dash
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000001;
        endcase
        return s;
    endfunction

    // Stage 1: box test, unit coordinates, digit select and blanking
    always_comb begin
        in_x_c    = ({1'b0, pixel_x} >= 12'(X0)) && ({1'b0, pixel_x} < 12'(X_END));
        in_y_c    = ({1'b0, pixel_y} >= 12'(Y0)) && ({1'b0, pixel_y} < 12'(Y_END));
        in_box_d  = in_x_c && in_y_c;
        dx_c      = pixel_x - 11'(X0);
        dy_c      = pixel_y - 11'(Y0);
        ux_full_c = dx_c >> SCALE_LOG2;
        uy_full_c = dy_c >> SCALE_LOG2;
        ux_c      = 4'd0;
        uy_d      = 3'd0;
        if (in_box_d) begin
            ux_c = 4'(ux_full_c);
            uy_d = 3'(uy_full_c);
        end

        digit_c = 2'd2;
        col_d   = 3'(ux_c - 4'd10);
        if (ux_c < 4'd5) begin
            digit_c = 2'd0;
            col_d   = 3'(ux_c);
        end else if (ux_c < 4'd10) begin
            digit_c = 2'd1;
            col_d   = 3'(ux_c - 4'd5);
        end

        nib_d   = shown_q[3:0];
        blank_d = 1'b0;
        case (digit_c)
            2'd0: begin
                nib_d   = shown_q[11:8];
                blank_d = (shown_q[11:8] == 4'd0);
            end
            2'd1: begin
                nib_d   = shown_q[7:4];
                blank_d = (shown_q[11:4] == 8'd0);
            end
            default: begin
                nib_d   = shown_q[3:0];
                blank_d = 1'b0;
            end
        endcase
    end

    // Stage 2: segment hit test and output mux
    always_comb begin
        seg_c = seg_decode(nib_q);
        lit_c = 1'b0;
        if (col_q <= 3'd3) begin
            lit_c = (seg_c[6] && (uy_q == 3'd0))
                 || (seg_c[5] && (col_q == 3'd3) && (uy_q <= 3'd3))
                 || (seg_c[4] && (col_q == 3'd3) && (uy_q >= 3'd3))
                 || (seg_c[3] && (uy_q == 3'd6))
                 || (seg_c[2] && (col_q == 3'd0) && (uy_q >= 3'd3))
                 || (seg_c[1] && (col_q == 3'd0) && (uy_q <= 3'd3))
                 || (seg_c[0] && (uy_q == 3'd3));
        end

        rgb_out_d = rgb1_q;
        if (!de1_q) begin
            rgb_out_d = 24'd0;
        end else if (in_box_q && !blank_q && lit_c) begin
            rgb_out_d = FG;
        end
    end

    // Frame-aligned capture of the value to display
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shown_q <= 12'h000;
        end else if (frame_start) begin
            shown_q <= valor_bcd;
        end
    end

    // Pipeline registers for both stages
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_box_q <= 1'b0;
            col_q    <= 3'd0;
            uy_q     <= 3'd0;
            nib_q    <= 4'd0;
            blank_q  <= 1'b0;
            de1_q    <= 1'b0;
            rgb1_q   <= 24'd0;
            de_out   <= 1'b0;
            rgb_out  <= 24'd0;
        end else begin
            in_box_q <= in_box_d;
            col_q    <= col_d;
            uy_q     <= uy_d;
            nib_q    <= nib_d;
            blank_q  <= blank_d;
            de1_q    <= de_in;
            rgb1_q   <= rgb_in;
            de_out   <= de1_q;
            rgb_out  <= rgb_out_d;
        end
    end

endmodule

// File: tb/tb_bcd_digit_overlay.sv
// Directed bench for bcd_digit_overlay with default geometry (unit = 4 px,
// box x 16..75, y 16..43).
module tb_bcd_digit_overlay;

    localparam logic [23:0] FGC = 24'hFFFFFF;
    localparam logic [23:0] BG  = 24'h102030;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] valor_bcd;
    logic        frame_start;
    logic [10:0] pixel_x;
    logic [10:0] pixel_y;
    logic        de_in;
    logic [23:0] rgb_in;
    logic        de_out;
    logic [23:0] rgb_out;

    int checks = 0;
    int errors = 0;

    logic        obs_de;
    logic [23:0] obs_rgb;

    bcd_digit_overlay dut (
        .clk         (clk),
        .reset       (reset),
        .valor_bcd   (valor_bcd),
        .frame_start (frame_start),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .de_in       (de_in),
        .rgb_in      (rgb_in),
        .de_out      (de_out),
        .rgb_out     (rgb_out)
    );

    always #5 clk = ~clk;

    // Present one pixel, return what appears 2 cycles later
    task automatic run_pixel(input int x, input int y, input logic de, input logic [23:0] rgb,
                             output logic o_de, output logic [23:0] o_rgb);
        @(negedge clk);
        pixel_x = 11'(x);
        pixel_y = 11'(y);
        de_in   = de;
        rgb_in  = rgb;
        @(negedge clk);
        de_in   = 1'b0;
        rgb_in  = 24'd0;
        @(negedge clk);
        o_de  = de_out;
        o_rgb = rgb_out;
    endtask

    // Latch a new value with a one-cycle frame_start pulse
    task automatic latch_value(input logic [11:0] v);
        @(negedge clk);
        valor_bcd   = v;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #1;
        checks++;
        if (de_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_de: got %b expected 0", de_out);
        end
        checks++;
        if (rgb_out !== 24'd0) begin
            errors++;
            $display("FAIL reset_rgb: got %h expected 000000", rgb_out);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run_pixel(56, 16, 1'b1, BG, obs_de, obs_rgb);
        checks++;
        if (obs_de !== 1'b1) begin
            errors++;
            $display("FAIL zero_a_de: got %b expected 1", obs_de);
        end
        checks++;
        if (obs_rgb !== FGC) begin
            errors++;
            $display("FAIL zero_a_rgb: got %h expected %h", obs_rgb, FGC);
        end
        run_pixel(60, 28, 1'b1, BG, obs_de, obs_rgb);
        checks++;
        if (obs_rgb !== BG) begin
            errors++;
            $display("FAIL zero_g_off: got %h expected %h", obs_rgb, BG);
        end
    endtask

    task automatic test_shadow;
        @(negedge clk);
        valor_bcd = 12'h123;
        run_pixel(28, 20, 1'b1, BG, obs_de, obs_rgb);
        checks++;
        if (obs_rgb !== BG) begin
            errors++;
            $display("FAIL shadow_unlatched: got %h expected %h", obs_rgb, BG);
        end
        latch_value(12'h123);
        run_pixel(28, 20, 1'b1, BG, obs_de, obs_rgb);
        checks++;
        if (obs_rgb !== FGC) begin
            errors++;
            $display("FAIL hund1_b: got %h expected %h", obs_rgb, FGC);
        end
        run_pixel(16, 16, 1'b1, BG, obs_de, obs_rgb);
        checks++;
        if (obs_rgb !== BG) begin
            errors++;
            $display("FAIL hund1_a_off: got %h expected %h", obs_rgb, BG);
        end
    endtask

    task automatic test_blanking;
        latch_value(12'h007);
        run_pixel(36, 16, 1'b1, BG, obs_de, obs_rgb);
        checks++;
        if (obs_rgb !== BG) begin
            errors++;
            $display("FAIL tens_blank: got %h expected %h", obs_rgb, BG);
        end
        run_pixel(56, 16, 1'b1, BG, obs_de, obs_rgb);
        checks++;
        if (obs_rgb !== FGC) begin
            errors++;
            $display("FAIL units7_a: got %h expected %h", obs_rgb, FGC);
        end
        latch_value(12'h070);
        run_pixel(36, 16, 1'b1, BG, obs_de, obs_rgb);
        checks++;
        if (obs_rgb !== FGC) begin
            errors++;
            $display("FAIL tens7_a: got %h expected %h", obs_rgb, FGC);
        end
        run_pixel(56, 40, 1'b1, BG, obs_de, obs_rgb);
        checks++;
        if (obs_rgb !== FGC) begin
            errors++;
            $display("FAIL units0_d: got %h expected %h", obs_rgb, FGC);
        end
        run_pixel(16, 16, 1'b1, BG, obs_de, obs_rgb);
        checks++;
        if (obs_rgb !== BG) begin
            errors++;
            $display("FAIL hund_blank: got %h expected %h", obs_rgb, BG);
        end
    endtask

    task automatic test_dash;
        latch_value(12'h0A5);
        run_pixel(36, 28, 1'b1, BG, obs_de, obs_rgb);
        checks++;
        if (obs_rgb !== FGC) begin
            errors++;
            $display("FAIL dash_g: got %h expected %h", obs_rgb, FGC);
        end
        run_pixel(36, 16, 1'b1, BG, obs_de, obs_rgb);
        checks++;
        if (obs_rgb !== BG) begin
            errors++;
            $display("FAIL dash_a_off: got %h expected %h", obs_rgb, BG);
        end
        latch_value(12'h00F);
        run_pixel(60, 28, 1'b1, BG, obs_de, obs_rgb);
        checks++;
        if (obs_rgb !== FGC) begin
            errors++;
            $display("FAIL units_dash: got %h expected %h", obs_rgb, FGC);
        end
    endtask

    task automatic test_edges;
        latch_value(12'h888);
        run_pixel(16, 16, 1'b1, BG, obs_de, obs_rgb);
        checks++;
        if (obs_rgb !== FGC) begin
            errors++;
            $display("FAIL corner_in: got %h expected %h", obs_rgb, FGC);
        end
        run_pixel(32, 16, 1'b1, BG, obs_de, obs_rgb);
        checks++;
        if (obs_rgb !== BG) begin
            errors++;
            $display("FAIL gap_col: got %h expected %h", obs_rgb, BG);
        end
        run_pixel(76, 16, 1'b1, BG, obs_de, obs_rgb);
        checks++;
        if (obs_rgb !== BG) begin
            errors++;
            $display("FAIL right_edge: got %h expected %h", obs_rgb, BG);
        end
        run_pixel(56, 44, 1'b1, BG, obs_de, obs_rgb);
        checks++;
        if (obs_rgb !== BG) begin
            errors++;
            $display("FAIL bottom_edge: got %h expected %h", obs_rgb, BG);
        end
        run_pixel(15, 16, 1'b1, BG, obs_de, obs_rgb);
        checks++;
        if (obs_rgb !== BG) begin
            errors++;
            $display("FAIL left_edge: got %h expected %h", obs_rgb, BG);
        end
        run_pixel(16, 15, 1'b1, BG, obs_de, obs_rgb);
        checks++;
        if (obs_rgb !== BG) begin
            errors++;
            $display("FAIL top_edge: got %h expected %h", obs_rgb, BG);
        end
        run_pixel(56, 16, 1'b0, BG, obs_de, obs_rgb);
        checks++;
        if (obs_de !== 1'b0) begin
            errors++;
            $display("FAIL de_low_de: got %b expected 0", obs_de);
        end
        checks++;
        if (obs_rgb !== 24'd0) begin
            errors++;
            $display("FAIL de_low_rgb: got %h expected 000000", obs_rgb);
        end
    endtask

    // Continuous stream; frame_start mid-stream switches 888 -> 100 exactly
    // for the pixel after the pulse
    task automatic test_back_to_back;
        int          px [5];
        int          py [5];
        logic        pde [5];
        logic [23:0] prgb [5];
        logic        exp_de [5];
        logic [23:0] exp_rgb [5];
        px = '{60, 60, 60, 32, 56};
        py = '{28, 28, 28, 16, 16};
        pde = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        prgb = '{24'h000001, 24'h000002, 24'h000003, 24'h000004, 24'h000005};
        exp_de = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_rgb = '{FGC, FGC, 24'h000003, 24'h000004, 24'h000000};
        latch_value(12'h888);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                checks++;
                if (de_out !== exp_de[i-2] || rgb_out !== exp_rgb[i-2]) begin
                    errors++;
                    $display("FAIL stream_%0d: got de=%b rgb=%h expected de=%b rgb=%h",
                             i - 2, de_out, rgb_out, exp_de[i-2], exp_rgb[i-2]);
                end
            end
            frame_start = 1'b0;
            if (i < 5) begin
                pixel_x = 11'(px[i]);
                pixel_y = 11'(py[i]);
                de_in   = pde[i];
                rgb_in  = prgb[i];
                if (i == 1) begin
                    valor_bcd   = 12'h100;
                    frame_start = 1'b1;
                end
            end else begin
                de_in  = 1'b0;
                rgb_in = 24'd0;
            end
        end
    endtask

    task automatic test_reset_midline;
        latch_value(12'h123);
        @(negedge clk);
        pixel_x = 11'd28;
        pixel_y = 11'd20;
        de_in   = 1'b1;
        rgb_in  = BG;
        repeat (3) @(negedge clk);
        checks++;
        if (de_out !== 1'b1 || rgb_out !== FGC) begin
            errors++;
            $display("FAIL pre_reset_stream: got de=%b rgb=%h expected de=1 rgb=%h",
                     de_out, rgb_out, FGC);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (de_out !== 1'b0 || rgb_out !== 24'd0) begin
            errors++;
            $display("FAIL async_reset: got de=%b rgb=%h expected de=0 rgb=000000",
                     de_out, rgb_out);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        de_in = 1'b0;
        run_pixel(28, 20, 1'b1, BG, obs_de, obs_rgb);
        checks++;
        if (obs_rgb !== BG) begin
            errors++;
            $display("FAIL post_reset_hund: got %h expected %h", obs_rgb, BG);
        end
        run_pixel(56, 16, 1'b1, BG, obs_de, obs_rgb);
        checks++;
        if (obs_rgb !== FGC) begin
            errors++;
            $display("FAIL post_reset_units: got %h expected %h", obs_rgb, FGC);
        end
    endtask

    initial begin
        reset       = 1'b1;
        valor_bcd   = 12'h000;
        frame_start = 1'b0;
        pixel_x     = 11'd0;
        pixel_y     = 11'd0;
        de_in       = 1'b0;
        rgb_in      = 24'd0;
        test_reset();
        test_shadow();
        test_blanking();
        test_dash();
        test_edges();
        test_back_to_back();
        test_reset_midline();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
